// File: rtl/paddle_move_ctrl.sv
// paddle_move_ctrl: turns debounced player buttons or an auto-tracking AI
// into rate-limited single-cycle step pulses for one paddle register
// (32-row playfield, 8-row paddle, bit 31 = top, bit 0 = bottom).
//
// Ports:
//   clk        - system clock, all logic on posedge
//   reset      - asynchronous, active-low; clears all state
//   btn_up     - raw asynchronous player up button, active-high
//   btn_down   - raw asynchronous player down button, active-high
//   ai_mode    - 1: AI drives the paddle and the buttons are ignored
//   ball_row   - ball row 0..31 (0 = bottom), synchronous to clk
//   ball_valid - ball_row is meaningful
//   paddle_pos - current paddle register contents (8 contiguous ones)
//   move_up    - one-cycle step-up pulse (registered)
//   move_down  - one-cycle step-down pulse (registered)
//   pos_err    - paddle_pos was all-zero on the previous cycle (registered)
module paddle_move_ctrl #(
    parameter logic [15:0] DEBOUNCE = 16'd50000,
    parameter logic [23:0] MOVE_DIV = 24'd500000,
    parameter logic [2:0]  DEADZONE = 3'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        ai_mode,
    input  logic [4:0]  ball_row,
    input  logic        ball_valid,
    input  logic [31:0] paddle_pos,
    output logic        move_up,
    output logic        move_down,
    output logic        pos_err
);

    localparam int unsigned DEB_W = 16;
    localparam int unsigned DIV_W = 24;
    localparam int unsigned ROW_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Button index 1 = up, 0 = down throughout the input path.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [DEB_W-1:0] cnt_q [2];
    logic [DEB_W-1:0] cnt_d [2];

    state_e           state_q, state_d;
    logic             dir_q, dir_d;          // 1 = up
    logic [DIV_W-1:0] wait_q, wait_d;
    logic             move_up_q, move_up_d;
    logic             move_down_q, move_down_d;
    logic             pos_err_q, pos_err_d;

    logic [4:0]       low_idx;
    logic [ROW_W-1:0] centre, ball6, dz6;
    logic             ai_up, ai_dn;
    logic             raw_up, raw_dn;
    logic             pad_ok;
    logic             up_req, down_req;

    // Debounce: the level follows the synced button only after it has
    // disagreed for DEBOUNCE consecutive samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEBOUNCE - 16'd1) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Priority encoder: lowest set bit of the paddle is its bottom row.
    always_comb begin
        low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (paddle_pos[i]) begin
                low_idx = 5'(i);
            end
        end
    end

    // AI tracking compare, all in 6 bits so nothing wraps.
    always_comb begin
        centre = 6'(low_idx) + 6'd4;
        ball6  = 6'(ball_row);
        dz6    = 6'(DEADZONE);
        ai_up  = ball_valid && (ball6 > (centre + dz6));
        ai_dn  = ball_valid && ((ball6 + dz6) < centre);
    end

    // Request source selection and playfield-edge masking.
    always_comb begin
        pad_ok = (paddle_pos != 32'd0);
        if (ai_mode) begin
            raw_up = ai_up;
            raw_dn = ai_dn;
        end else begin
            raw_up = deb_q[1] & ~deb_q[0];
            raw_dn = deb_q[0] & ~deb_q[1];
        end
        up_req   = raw_up & pad_ok & ~paddle_pos[31];
        down_req = raw_dn & pad_ok & ~paddle_pos[0];
    end

    // Step sequencer: one STEP cycle, then a WAIT of MOVE_DIV-1 cycles so
    // held requests pulse exactly every MOVE_DIV cycles.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (up_req) begin
                    state_d = ST_STEP;
                    dir_d   = 1'b1;
                end else if (down_req) begin
                    state_d = ST_STEP;
                    dir_d   = 1'b0;
                end
            end
            ST_STEP: begin
                state_d = ST_WAIT;
                wait_d  = MOVE_DIV - 24'd2;
            end
            ST_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 24'd1;
                end else if (dir_q ? up_req : down_req) begin
                    state_d = ST_STEP;
                end else if (dir_q ? down_req : up_req) begin
                    state_d = ST_STEP;
                    dir_d   = ~dir_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        move_up_d   = (state_d == ST_STEP) &  dir_d;
        move_down_d = (state_d == ST_STEP) & ~dir_d;
        pos_err_d   = ~pad_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            wait_q      <= '0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            pos_err_q   <= 1'b0;
        end else begin
            sync1_q     <= {btn_up, btn_down};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            state_q     <= state_d;
            dir_q       <= dir_d;
            wait_q      <= wait_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
            pos_err_q   <= pos_err_d;
        end
    end

    assign move_up   = move_up_q;
    assign move_down = move_down_q;
    assign pos_err   = pos_err_q;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Self-checking bench for paddle_move_ctrl with DEBOUNCE=4, MOVE_DIV=8,
// DEADZONE=1: directed scenarios with literal expectations, then random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_paddle_move_ctrl;

    localparam int DEBOUNCE = 4;
    localparam int MOVE_DIV = 8;
    localparam int DEADZONE = 1;

    logic        clk;
    logic        reset;
    logic        btn_up, btn_down, ai_mode, ball_valid;
    logic [4:0]  ball_row;
    logic [31:0] paddle_pos;
    logic        move_up, move_down, pos_err;

    int errors = 0;
    int checks = 0;
    int n_up, n_dn;

    paddle_move_ctrl #(
        .DEBOUNCE(16'(DEBOUNCE)),
        .MOVE_DIV(24'(MOVE_DIV)),
        .DEADZONE(3'(DEADZONE))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .ai_mode   (ai_mode),
        .ball_row  (ball_row),
        .ball_valid(ball_valid),
        .paddle_pos(paddle_pos),
        .move_up   (move_up),
        .move_down (move_down),
        .pos_err   (pos_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw button history, newest in bit 0. The synced sample seen at an edge
    // is the raw value from two edges earlier, so the debounce window is
    // bits [DEBOUNCE+1:2].
    logic [DEBOUNCE+1:0] hist_u, hist_d;
    logic [DEBOUNCE-1:0] win;
    bit     m_deb_u, m_deb_d;
    bit     exp_up, exp_dn, exp_err;
    bit     m_ru, m_rd;
    longint cyc, last_pulse;

    function automatic void ai_requests(output bit u, output bit d);
        int l, c, br;
        l = 0;
        for (int i = 31; i >= 0; i--) if (paddle_pos[i]) l = i;
        c  = l + 4;
        br = int'(ball_row);
        u  = ball_valid && (br > c + DEADZONE);
        d  = ball_valid && (br + DEADZONE < c);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_u = '0; hist_d = '0;
            m_deb_u = 0; m_deb_d = 0;
            exp_up = 0; exp_dn = 0; exp_err = 0;
            cyc = 0; last_pulse = -1000;
        end else begin
            if (ai_mode) ai_requests(m_ru, m_rd);
            else begin
                m_ru = m_deb_u && !m_deb_d;
                m_rd = m_deb_d && !m_deb_u;
            end
            if (paddle_pos == 32'd0) begin m_ru = 0; m_rd = 0; end
            if (paddle_pos[31]) m_ru = 0;
            if (paddle_pos[0])  m_rd = 0;
            // A pulse is allowed whenever MOVE_DIV cycles have elapsed
            // since the previous one.
            exp_up = 0; exp_dn = 0;
            if ((m_ru || m_rd) && (cyc - last_pulse >= MOVE_DIV)) begin
                exp_up = m_ru;
                exp_dn = !m_ru;
                last_pulse = cyc;
            end
            exp_err = (paddle_pos == 32'd0);
            hist_u = {hist_u[DEBOUNCE:0], btn_up};
            hist_d = {hist_d[DEBOUNCE:0], btn_down};
            win = hist_u[DEBOUNCE+1:2];
            if (m_deb_u ? (win == '0) : (&win)) m_deb_u = !m_deb_u;
            win = hist_d[DEBOUNCE+1:2];
            if (m_deb_d ? (win == '0) : (&win)) m_deb_d = !m_deb_d;
            cyc++;
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            check("move_up",   32'(move_up),   32'(exp_up));
            check("move_down", 32'(move_down), 32'(exp_dn));
            check("pos_err",   32'(pos_err),   32'(exp_err));
            if (move_up && move_down) check("exclusive", 32'd1, 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (move_up)   n_up++;
            if (move_down) n_dn++;
        end
    endtask

    task automatic first_up(input int limit, output int first);
        first = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (move_up && first < 0) first = k;
        end
    endtask

    initial begin
        int first, p;
        bit found;
        reset = 1'b0; btn_up = 0; btn_down = 0; ai_mode = 0;
        ball_valid = 0; ball_row = 5'd0; paddle_pos = 32'd0;
        n_up = 0; n_dn = 0;

        // Reset holds everything low even with an all-zero paddle.
        tick(3);
        check("rst_move_up",   32'(move_up),   32'd0);
        check("rst_move_down", 32'(move_down), 32'd0);
        check("rst_pos_err",   32'(pos_err),   32'd0);
        paddle_pos = 32'h000FF000;
        reset = 1'b1;
        tick(2);

        // Held button: first pulse on the 7th edge, then every 8 cycles.
        btn_up = 1; n_up = 0; first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (move_up) begin
                n_up++;
                if (first < 0) first = k;
            end
        end
        check("btn_first_latency", 32'(first), 32'd7);
        check("btn_pulse_count",   32'(n_up),  32'd5);
        btn_up = 0;
        tick(20);

        // Reset asserted during a STEP clears the output immediately.
        btn_up = 1; found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(posedge clk);
            #1;
            if (move_up) found = 1;
        end
        check("step_found", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_step", 32'(move_up), 32'd0);
        tick(1);
        reset = 1'b1;
        first_up(20, first);
        check("latency_after_reset", 32'(first), 32'd7);
        btn_up = 0;
        tick(20);

        // Short glitch and both-buttons produce nothing.
        n_up = 0; n_dn = 0;
        btn_up = 1; tick(3); btn_up = 0; tick(20);
        check("glitch_no_pulse", 32'(n_up + n_dn), 32'd0);
        btn_up = 1; btn_down = 1; tick(30);
        check("both_no_pulse", 32'(n_up + n_dn), 32'd0);
        btn_up = 0; btn_down = 0; tick(10);

        // Playfield edges.
        paddle_pos = 32'hFF000000; btn_up = 1; n_up = 0; tick(30);
        check("top_limit", 32'(n_up), 32'd0);
        btn_up = 0; tick(10);
        paddle_pos = 32'h000000FF; btn_down = 1; n_dn = 0; tick(30);
        check("bottom_limit", 32'(n_dn), 32'd0);
        btn_down = 0; tick(10);

        // AI tracking around centre 16 with deadzone 1.
        paddle_pos = 32'h000FF000; ai_mode = 1; ball_valid = 1; ball_row = 5'd20;
        tick(1);
        check("ai_up_20", 32'(move_up), 32'd1);
        ball_row = 5'd17; n_up = 0; n_dn = 0; tick(12);
        check("ai_dead_17", 32'(n_up + n_dn), 32'd0);
        ball_row = 5'd10; tick(1);
        check("ai_down_10", 32'(move_down), 32'd1);
        ball_valid = 0; n_up = 0; n_dn = 0; tick(12);
        check("ai_invalid", 32'(n_up + n_dn), 32'd0);
        ball_valid = 1; ball_row = 5'd18; tick(1);
        check("ai_up_18", 32'(move_up), 32'd1);
        ball_row = 5'd15; n_up = 0; n_dn = 0; tick(12);
        check("ai_dead_15", 32'(n_up + n_dn), 32'd0);
        ball_row = 5'd14; tick(1);
        check("ai_down_14", 32'(move_down), 32'd1);
        tick(10);

        // All-zero paddle flags an error and blocks moves.
        ai_mode = 0; ball_valid = 0;
        paddle_pos = 32'd0; tick(1);
        check("pos_err_set", 32'(pos_err), 32'd1);
        paddle_pos = 32'h000FF000; tick(1);
        check("pos_err_clr", 32'(pos_err), 32'd0);

        // Random phase; the every-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!reset) reset = 1'b1;
            if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 149) == 0) ai_mode = ~ai_mode;
            if ($urandom_range(0, 39) == 0) ball_valid = ~ball_valid;
            if ($urandom_range(0, 5) == 0) ball_row = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) begin
                p = int'($urandom_range(0, 24));
                paddle_pos = 32'h000000FF << p;
            end
            if ($urandom_range(0, 79) == 0) paddle_pos = 32'd0;
            if ($urandom_range(0, 399) == 0) reset = 1'b0;
        end
        reset = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
